// File: rtl/pulse_scheduler.sv
// Shares one programmable-width pulse timer among N requesters using a
// round-robin arbiter; each grant produces a pulse of the latched width, then an idle gap.
module pulse_scheduler #(
    parameter int N   = 4,
    parameter int W   = 4,
    parameter int GAP = 1
) (
    input  logic           clock,
    input  logic           reset_n,
    input  logic [N-1:0]   req,
    input  logic [N*W-1:0] width,
    output logic           pulse,
    output logic [N-1:0]   grant,
    output logic [N-1:0]   done,
    output logic           busy
);

    localparam int PW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PULSE,
        ST_GAP
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   cnt_q, cnt_d;
    logic [PW-1:0]  ptr_q, ptr_d;
    logic [PW-1:0]  idx_q, idx_d;
    logic           pulse_q, pulse_d;
    logic [N-1:0]   grant_q, grant_d;
    logic [N-1:0]   done_q, done_d;

    logic           found;
    logic [PW-1:0]  win_idx;
    logic [W-1:0]   win_width;
    logic [W-1:0]   win_len;
    int             cand;

    // Scan requesters starting at the round-robin pointer, wrapping mod N.
    always_comb begin
        found   = 1'b0;
        win_idx = '0;
        cand    = 0;
        for (int k = 0; k < N; k++) begin
            cand = (int'(ptr_q) + k) % N;
            if (!found && req[cand]) begin
                found   = 1'b1;
                win_idx = PW'(cand);
            end
        end
    end

    // A programmed width of zero still yields a one-cycle pulse.
    always_comb begin
        win_width = width[win_idx*W +: W];
        win_len   = (win_width == '0) ? W'(1) : win_width;
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        pulse_d = pulse_q;
        grant_d = grant_q;
        done_d  = '0;
        case (state_q)
            ST_IDLE: begin
                pulse_d = 1'b0;
                grant_d = '0;
                if (found) begin
                    idx_d   = win_idx;
                    cnt_d   = win_len - W'(1);
                    state_d = ST_PULSE;
                    pulse_d = 1'b1;
                    grant_d = N'(1) << win_idx;
                end
            end
            ST_PULSE: begin
                if (cnt_q == '0) begin
                    pulse_d = 1'b0;
                    done_d  = N'(1) << idx_q;
                    ptr_d   = (idx_q == PW'(N - 1)) ? '0 : idx_q + PW'(1);
                    if (GAP == 0) begin
                        state_d = ST_IDLE;
                        grant_d = '0;
                    end else begin
                        state_d = ST_GAP;
                        cnt_d   = W'((GAP > 0) ? GAP - 1 : 0);
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            ST_GAP: begin
                pulse_d = 1'b0;
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    grant_d = '0;
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                pulse_d = 1'b0;
                grant_d = '0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            idx_q   <= '0;
            pulse_q <= 1'b0;
            grant_q <= '0;
            done_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            pulse_q <= pulse_d;
            grant_q <= grant_d;
            done_q  <= done_d;
        end
    end

    assign pulse = pulse_q;
    assign grant = grant_q;
    assign done  = done_q;
    assign busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_pulse_scheduler.sv
// Directed self-checking bench for pulse_scheduler (N=4, W=4, GAP=1).
module tb_pulse_scheduler;

    logic        clock;
    logic        reset_n;
    logic [3:0]  req;
    logic [15:0] width;
    logic        pulse;
    logic [3:0]  grant;
    logic [3:0]  done;
    logic        busy;

    int checks;
    int failures;

    pulse_scheduler #(.N(4), .W(4), .GAP(1)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .req     (req),
        .width   (width),
        .pulse   (pulse),
        .grant   (grant),
        .done    (done),
        .busy    (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic applyStimulus();
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic exp_pulse, input logic [3:0] exp_grant,
                               input logic [3:0] exp_done, input logic exp_busy);
        checks++;
        assert ({pulse, grant, done, busy} === {exp_pulse, exp_grant, exp_done, exp_busy})
        else begin
            failures++;
            $error("[TB] FAIL %s: got pulse=%b grant=%b done=%b busy=%b, expected pulse=%b grant=%b done=%b busy=%b",
                   tag, pulse, grant, done, busy, exp_pulse, exp_grant, exp_done, exp_busy);
        end
    endtask

    initial begin
        logic [3:0] g;
        int         len;
        checks   = 0;
        failures = 0;

        reset_n = 1'b0;
        req     = 4'b1111;
        width   = {4'd4, 4'd3, 4'd2, 4'd1};
        applyStimulus();
        applyStimulus();
        checkOutput("reset_state", 1'b0, 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        applyStimulus();
        checkOutput("first_grant", 1'b1, 4'b0001, 4'b0000, 1'b1);

        reset_n = 1'b0;
        applyStimulus();
        checkOutput("reset_again", 1'b0, 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        req     = 4'b0001;
        width   = {4'd4, 4'd3, 4'd2, 4'd3};
        applyStimulus();
        req = 4'b0000;
        checkOutput("single_p1", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("single_p2", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("single_p3", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("single_done", 1'b0, 4'b0001, 4'b0001, 1'b1);
        applyStimulus();
        checkOutput("single_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);

        // Round robin from a fresh pointer: grants 0,1,2,3,0 with lengths 1..4.
        reset_n = 1'b0;
        applyStimulus();
        reset_n = 1'b1;
        req     = 4'b1111;
        width   = {4'd4, 4'd3, 4'd2, 4'd1};
        for (int n = 0; n < 5; n++) begin
            g   = 4'b0001 << (n % 4);
            len = (n % 4) + 1;
            applyStimulus();
            checkOutput("rr_grant", 1'b1, g, 4'b0000, 1'b1);
            if (n == 4) req = 4'b0000;
            for (int c = 1; c < len; c++) begin
                applyStimulus();
                checkOutput("rr_pulse", 1'b1, g, 4'b0000, 1'b1);
            end
            applyStimulus();
            checkOutput("rr_done", 1'b0, g, g, 1'b1);
            applyStimulus();
            checkOutput("rr_gap_low", 1'b0, 4'b0000, 4'b0000, 1'b0);
        end

        req   = 4'b0100;
        width = {4'd4, 4'd0, 4'd2, 4'd1};
        applyStimulus();
        req = 4'b0000;
        checkOutput("zero_w_pulse", 1'b1, 4'b0100, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("zero_w_done", 1'b0, 4'b0100, 4'b0100, 1'b1);
        applyStimulus();
        checkOutput("zero_w_idle", 1'b0, 4'b0000, 4'b0000, 1'b0);
        req = 4'b1001;
        applyStimulus();
        checkOutput("ptr_at_3", 1'b1, 4'b1000, 4'b0000, 1'b1);
        req = 4'b0000;

        reset_n = 1'b0;
        applyStimulus();
        checkOutput("reset_mid", 1'b0, 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        req     = 4'b0010;
        width   = {4'd4, 4'd0, 4'd5, 4'd1};
        applyStimulus();
        checkOutput("mr_p1", 1'b1, 4'b0010, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("mr_p2", 1'b1, 4'b0010, 4'b0000, 1'b1);
        reset_n = 1'b0;
        applyStimulus();
        checkOutput("mr_abort", 1'b0, 4'b0000, 4'b0000, 1'b0);
        reset_n = 1'b1;
        req     = 4'b0011;
        applyStimulus();
        checkOutput("mr_ptr0", 1'b1, 4'b0001, 4'b0000, 1'b1);
        req = 4'b0000;
        applyStimulus();
        checkOutput("mr_done", 1'b0, 4'b0001, 4'b0001, 1'b1);
        applyStimulus();

        // Dropping req and shrinking width mid-pulse must not shorten the pulse.
        reset_n = 1'b0;
        applyStimulus();
        reset_n = 1'b1;
        req     = 4'b1001;
        width   = {4'd4, 4'd0, 4'd5, 4'd4};
        applyStimulus();
        checkOutput("mc_p1", 1'b1, 4'b0001, 4'b0000, 1'b1);
        req   = 4'b1000;
        width = {4'd4, 4'd0, 4'd5, 4'd1};
        applyStimulus();
        checkOutput("mc_p2", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("mc_p3", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("mc_p4", 1'b1, 4'b0001, 4'b0000, 1'b1);
        applyStimulus();
        checkOutput("mc_done", 1'b0, 4'b0001, 4'b0001, 1'b1);
        applyStimulus();
        checkOutput("mc_gap", 1'b0, 4'b0000, 4'b0000, 1'b0);
        applyStimulus();
        checkOutput("mc_next_req3", 1'b1, 4'b1000, 4'b0000, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
